alu_branch_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_branch_unit_if.sv | 25 ++
 rtl/alu_shifter.sv | 40 ++++
 rtl/alu_branch_unit.sv | 70 +++++++
 tb/tb_alu_branch_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the alu_branch_unit execute stage.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_ROR = 3'b111;

  typedef enum logic [2:0] {
    OP_FWD = ALU_FWD,
    OP_ADD = ALU_ADD,
    OP_AND = ALU_AND,
    OP_OR  = ALU_OR,
    OP_SLL = ALU_SLL,
    OP_SRL = ALU_SRL,
    OP_SRA = ALU_SRA,
    OP_ROR = ALU_ROR
  } alu_op_t;

endpackage

// File: rtl/alu_branch_unit_if.sv
// Operand/control/result bundle between the decode/regfile side (master) and the execute stage (slave).
interface alu_branch_unit_if;
  import alu_pkg::*;

  logic                 STALL;
  logic [ALU_WIDTH-1:0] DATA1;
  logic [ALU_WIDTH-1:0] DATA2;
  logic [2:0]           ALUOP;
  logic                 BRANCH_SELECT;
  logic                 BNE_SELECT;
  logic [ALU_WIDTH-1:0] ALU_RESULT;
  logic                 ISZERO;
  logic                 DOBRANCH;
  logic                 DOBNE;

  modport master (
    output STALL, DATA1, DATA2, ALUOP, BRANCH_SELECT, BNE_SELECT,
    input  ALU_RESULT, ISZERO, DOBRANCH, DOBNE
  );

  modport slave (
    input  STALL, DATA1, DATA2, ALUOP, BRANCH_SELECT, BNE_SELECT,
    output ALU_RESULT, ISZERO, DOBRANCH, DOBNE
  );
endinterface

// File: rtl/alu_shifter.sv
// Combinational SLL/SRL/SRA/ROR; op is ALUOP[1:0]. Shift amounts of 8 or more saturate, rotates use amount mod 8.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] data1,
  input  logic [ALU_WIDTH-1:0] data2,
  input  logic [1:0]           op,
  output logic [ALU_WIDTH-1:0] result
);

  logic       big_s;
  logic [2:0] amt_s;
  logic [7:0] rot_s;

  assign big_s = |data2[7:3];
  assign amt_s = data2[2:0];
  assign rot_s = 8'({data1, data1} >> amt_s);

  // Shift/rotate select
  always_comb begin
    result = 8'h00;
    case (op)
      2'b00: begin
        if (big_s) result = 8'h00;
        else       result = data1 << amt_s;
      end
      2'b01: begin
        if (big_s) result = 8'h00;
        else       result = data1 >> amt_s;
      end
      2'b10: begin
        if (big_s) result = {ALU_WIDTH{data1[7]}};
        else       result = 8'($signed(data1) >>> amt_s);
      end
      2'b11:   result = rot_s;
      default: result = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_branch_unit.sv
// Registered 8-bit ALU with zero flag and BEQ/BNE resolution.
// Define ALU_SHIFT_EN to include the shifter; otherwise ALUOP 100-111 yield 8'h00.
module alu_branch_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  alu_branch_unit_if.slave   bus
);

  alu_op_t          op_s;
  logic [WIDTH-1:0] result_s;
  logic [WIDTH-1:0] shift_s;
  logic             zero_s;
  logic [WIDTH-1:0] result_r;
  logic             iszero_r;
  logic             dobranch_r;
  logic             dobne_r;

  assign op_s = alu_op_t'(bus.ALUOP);

`ifdef ALU_SHIFT_EN
  alu_shifter u_shifter (
    .data1  (bus.DATA1),
    .data2  (bus.DATA2),
    .op     (bus.ALUOP[1:0]),
    .result (shift_s)
  );
`else
  assign shift_s = 8'h00;
`endif

  // Operation mux; every opcode has a defined result
  always_comb begin
    result_s = 8'h00;
    case (op_s)
      OP_FWD:                         result_s = bus.DATA2;
      OP_ADD:                         result_s = bus.DATA1 + bus.DATA2;
      OP_AND:                         result_s = bus.DATA1 & bus.DATA2;
      OP_OR:                          result_s = bus.DATA1 | bus.DATA2;
      OP_SLL, OP_SRL, OP_SRA, OP_ROR: result_s = shift_s;
      default:                        result_s = 8'h00;
    endcase
  end

  assign zero_s = (result_s == 8'h00);

  // Output registers: reset beats stall, stall holds everything
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      result_r   <= 8'h00;
      iszero_r   <= 1'b0;
      dobranch_r <= 1'b0;
      dobne_r    <= 1'b0;
    end else if (!bus.STALL) begin
      result_r   <= result_s;
      iszero_r   <= zero_s;
      dobranch_r <= bus.BRANCH_SELECT & zero_s;
      dobne_r    <= bus.BNE_SELECT & ~zero_s;
    end
  end

  assign bus.ALU_RESULT = result_r;
  assign bus.ISZERO     = iszero_r;
  assign bus.DOBRANCH   = dobranch_r;
  assign bus.DOBNE      = dobne_r;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed self-checking bench for alu_branch_unit; shift vectors depend on ALU_SHIFT_EN.
module tb_alu_branch_unit;
  import alu_pkg::*;

  typedef struct packed {
    logic        stall;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [2:0]  op;
    logic        bs;
    logic        bn;
    logic [10:0] exp;
  } vec_t;

  logic CLK;
  logic RESET;
  int   tests_run;
  int   fails;

  alu_branch_unit_if bus ();

  alu_branch_unit #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic s, input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] op, input logic bs, input logic bn,
                              input logic [7:0] r, input logic z, input logic eb, input logic en);
    vec_t v;
    v.stall = s; v.d1 = a; v.d2 = b; v.op = op; v.bs = bs; v.bn = bn;
    v.exp = {r, z, eb, en};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.STALL         = v.stall;
    bus.DATA1         = v.d1;
    bus.DATA2         = v.d2;
    bus.ALUOP         = v.op;
    bus.BRANCH_SELECT = v.bs;
    bus.BNE_SELECT    = v.bn;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    RESET = 1'b0;
    drive(mk(1'b0, 8'h01, 8'hFF, ALU_ADD, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    drive(mk(1'b1, 8'h07, 8'h03, ALU_OR, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
    got = {bus.ALU_RESULT, bus.ISZERO, bus.DOBRANCH, bus.DOBNE};
    tests_run++;
    if (got !== 11'h000) begin
      fails++;
      $display("FAIL reset_state got=%h exp=%h", got, 11'h000);
    end
    RESET = 1'b1;
    drive(mk(1'b0, 8'h00, 8'h5A, ALU_FWD, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    got = {bus.ALU_RESULT, bus.ISZERO, bus.DOBRANCH, bus.DOBNE};
    tests_run++;
    if (got !== {8'h5A, 3'b000}) begin
      fails++;
      $display("FAIL reset_release_fwd got=%h exp=%h", got, {8'h5A, 3'b000});
    end
  endtask

  task automatic test_branch();
    vec_t        q[$];
    logic [10:0] got;
    q.push_back(mk(1'b0, 8'h05, 8'hFB, ALU_ADD, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 8'h00, 8'h11, ALU_FWD, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h07, 8'hFB, ALU_ADD, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1));
    q.push_back(mk(1'b0, 8'h07, 8'hF9, ALU_ADD, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h09, 8'hFB, ALU_ADD, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h01, 8'hFF, ALU_ADD, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 8'h01, 8'h01, ALU_ADD, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1));
    q.push_back(mk(1'b0, 8'hC8, 8'h64, ALU_ADD, 1'b0, 1'b0, 8'h2C, 1'b0, 1'b0, 1'b0));
    foreach (q[i]) begin
      drive(q[i]);
      got = {bus.ALU_RESULT, bus.ISZERO, bus.DOBRANCH, bus.DOBNE};
      tests_run++;
      if (got !== q[i].exp) begin
        fails++;
        $display("FAIL branch[%0d] got=%h exp=%h", i, got, q[i].exp);
      end
    end
  endtask

  task automatic test_logic();
    vec_t        q[$];
    logic [10:0] got;
    q.push_back(mk(1'b0, 8'hF0, 8'h3C, ALU_AND, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'hF0, 8'h0F, ALU_OR,  1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'hF0, 8'h0F, ALU_AND, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 8'hAA, 8'h00, ALU_FWD, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0));
    foreach (q[i]) begin
      drive(q[i]);
      got = {bus.ALU_RESULT, bus.ISZERO, bus.DOBRANCH, bus.DOBNE};
      tests_run++;
      if (got !== q[i].exp) begin
        fails++;
        $display("FAIL logic[%0d] got=%h exp=%h", i, got, q[i].exp);
      end
    end
  endtask

  task automatic test_shifts();
    vec_t        q[$];
    logic [10:0] got;
`ifdef ALU_SHIFT_EN
    q.push_back(mk(1'b0, 8'h80, 8'h03, ALU_SRA, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h80, 8'h03, ALU_SRL, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h81, 8'h09, ALU_SLL, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h81, 8'h01, ALU_ROR, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h81, 8'h09, ALU_ROR, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h80, 8'h08, ALU_SRA, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h7F, 8'h08, ALU_SRA, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h81, 8'h01, ALU_SLL, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h81, 8'h08, ALU_SRL, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
`else
    q.push_back(mk(1'b0, 8'h01, 8'h01, ALU_SLL, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h80, 8'h01, ALU_SRL, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 8'h80, 8'h01, ALU_SRA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 8'h81, 8'h01, ALU_ROR, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
`endif
    foreach (q[i]) begin
      drive(q[i]);
      got = {bus.ALU_RESULT, bus.ISZERO, bus.DOBRANCH, bus.DOBNE};
      tests_run++;
      if (got !== q[i].exp) begin
        fails++;
        $display("FAIL shift[%0d] got=%h exp=%h", i, got, q[i].exp);
      end
    end
  endtask

  task automatic test_stall_reset();
    vec_t        q[$];
    logic [10:0] got;
    // load a taken BEQ, then hold it for three cycles while inputs change
    q.push_back(mk(1'b0, 8'h05, 8'hFB, ALU_ADD, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(1'b1, 8'h12, 8'hAA, ALU_FWD, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(1'b1, 8'h33, 8'h44, ALU_OR,  1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(1'b1, 8'h0F, 8'h01, ALU_ADD, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 8'h00, 8'h33, ALU_FWD, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1));
    q.push_back(mk(1'b1, 8'h00, 8'h77, ALU_FWD, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1));
    foreach (q[i]) begin
      drive(q[i]);
      got = {bus.ALU_RESULT, bus.ISZERO, bus.DOBRANCH, bus.DOBNE};
      tests_run++;
      if (got !== q[i].exp) begin
        fails++;
        $display("FAIL stall[%0d] got=%h exp=%h", i, got, q[i].exp);
      end
    end
    RESET = 1'b0;
    drive(mk(1'b1, 8'h01, 8'h02, ALU_ADD, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
    got = {bus.ALU_RESULT, bus.ISZERO, bus.DOBRANCH, bus.DOBNE};
    tests_run++;
    if (got !== 11'h000) begin
      fails++;
      $display("FAIL reset_over_stall got=%h exp=%h", got, 11'h000);
    end
    RESET = 1'b1;
    drive(mk(1'b0, 8'h20, 8'h24, ALU_ADD, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    got = {bus.ALU_RESULT, bus.ISZERO, bus.DOBRANCH, bus.DOBNE};
    tests_run++;
    if (got !== {8'h44, 3'b000}) begin
      fails++;
      $display("FAIL after_reset_add got=%h exp=%h", got, {8'h44, 3'b000});
    end
  endtask

  initial begin
    tests_run         = 0;
    fails             = 0;
    RESET             = 1'b0;
    bus.STALL         = 1'b0;
    bus.DATA1         = 8'h00;
    bus.DATA2         = 8'h00;
    bus.ALUOP         = 3'b000;
    bus.BRANCH_SELECT = 1'b0;
    bus.BNE_SELECT    = 1'b0;
    #2;
    test_reset();
    test_branch();
    test_logic();
    test_shifts();
    test_stall_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
